// File: rtl/keyed_secded_pipe.sv
// Key-locked, two-stage pipelined SEC-DED corrector with serial key loading
// and saturating on-chip counters for corrected and uncorrectable words.
module keyed_secded_pipe #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        KEY_W     = 4,
    parameter logic [KEY_W-1:0]   KEY_CONST = 4'b1010,
    parameter int unsigned        CNT_W     = 16,
    localparam int unsigned       P         = $clog2(DATA_W + $clog2(DATA_W + 1) + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic              key_bit,
    output logic              key_armed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [P:0]        in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    localparam int unsigned N      = DATA_W + P;
    localparam int unsigned STRIDE = DATA_W / KEY_W;
    localparam int unsigned KB_W   = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    // Codeword position of data bit idx: idx-th non-power-of-two position.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned pos;
        int unsigned cnt;
        pos = 0;
        cnt = 0;
        for (int unsigned q = 1; q <= N; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == idx) pos = q;
                cnt++;
            end
        end
        return pos;
    endfunction

    state_t            r_state, w_state_nxt;
    logic              w_shift_en, w_key_commit;
    logic [KB_W-1:0]   r_bit_cnt;
    logic [KEY_W-1:0]  r_shadow, r_key, w_shadow_nxt, w_delta;
    logic              r_key_armed;

    logic              w_s1_en, w_s2_en, w_in_ready, w_out_hs;
    logic              r_s1_v, r_s1_p;
    logic [DATA_W-1:0] r_s1_data;
    logic [P-1:0]      r_s1_syn;
    logic [DATA_W-1:0] w_keyed, w_corr;
    logic [P-1:0]      w_recalc, w_syn;
    logic              w_par, w_sec, w_ded;

    logic              r_out_valid, r_out_sec, r_out_ded;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_sec_cnt, r_ded_cnt;

    // Key load FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_en   = 1'b0;
        w_key_commit = 1'b0;
        case (r_state)
            ST_IDLE:  if (key_load) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                w_shift_en = 1'b1;
                if (r_bit_cnt == KB_W'(KEY_W - 1)) begin
                    w_key_commit = 1'b1;
                    w_state_nxt  = ST_ARMED;
                end
            end
            ST_ARMED: if (key_load) w_state_nxt = ST_SHIFT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_shadow_nxt = {r_shadow[KEY_W-2:0], key_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_shadow    <= '0;
            r_key       <= '0;
            r_key_armed <= 1'b0;
        end else begin
            r_key_armed <= (w_state_nxt == ST_ARMED);
            if (w_shift_en) begin
                r_shadow  <= w_shadow_nxt;
                r_bit_cnt <= w_key_commit ? '0 : r_bit_cnt + 1'b1;
            end
            if (w_key_commit) r_key <= w_shadow_nxt;
        end
    end

    assign w_delta    = r_key ^ KEY_CONST;
    assign w_s2_en    = ~r_out_valid | out_ready;
    assign w_s1_en    = ~r_s1_v | w_s2_en;
    assign w_in_ready = w_s1_en & (r_state != ST_SHIFT);
    assign w_out_hs   = r_out_valid & out_ready;

    // Stage 1: key scrambling, syndrome and overall parity
    always_comb begin
        w_keyed = in_data;
        for (int unsigned j = 0; j < KEY_W; j++) begin
            w_keyed[j*STRIDE] = in_data[j*STRIDE] ^ w_delta[j];
        end
        w_recalc = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            for (int unsigned k = 0; k < P; k++) begin
                if (((data_pos(i) >> k) & 32'd1) == 32'd1) w_recalc[k] = w_recalc[k] ^ w_keyed[i];
            end
        end
        w_syn = w_recalc ^ in_chk[P-1:0];
        w_par = (^w_keyed) ^ (^in_chk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_p    <= 1'b0;
            r_s1_data <= '0;
            r_s1_syn  <= '0;
        end else if (w_s1_en) begin
            r_s1_v    <= in_valid & w_in_ready;
            r_s1_p    <= w_par;
            r_s1_data <= w_keyed;
            r_s1_syn  <= w_syn;
        end
    end

    // Stage 2: classify and correct; power-of-two syndromes match no data bit
    always_comb begin
        w_corr = r_s1_data;
        w_sec  = 1'b0;
        w_ded  = 1'b0;
        if (r_s1_p) begin
            if (r_s1_syn == '0) begin
                w_sec = 1'b1;
            end else if (32'(r_s1_syn) > N) begin
                w_ded = 1'b1;
            end else begin
                w_sec = 1'b1;
                for (int unsigned i = 0; i < DATA_W; i++) begin
                    if (data_pos(i) == 32'(r_s1_syn)) w_corr[i] = ~r_s1_data[i];
                end
            end
        end else if (r_s1_syn != '0) begin
            w_ded = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sec   <= 1'b0;
            r_out_ded   <= 1'b0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_v;
            r_out_data  <= w_corr;
            r_out_sec   <= w_sec & r_s1_v;
            r_out_ded   <= w_ded & r_s1_v;
        end
    end

    // Saturating counters, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (cnt_clr) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            if (w_out_hs && r_out_sec && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + 1'b1;
            if (w_out_hs && r_out_ded && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + 1'b1;
        end
    end

    assign key_armed = r_key_armed;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sec   = r_out_sec;
    assign out_ded   = r_out_ded;
    assign sec_cnt   = r_sec_cnt;
    assign ded_cnt   = r_ded_cnt;

endmodule

// File: tb/tb_keyed_secded_pipe.sv
// Self-checking bench for keyed_secded_pipe: directed and random words scored
// against a codeword-level Hamming model with a queue of expected outputs.
module tb_keyed_secded_pipe;

    logic        clk, rst_n, key_load, key_bit, key_armed;
    logic        in_valid, in_ready, out_valid, out_ready, out_sec, out_ded, cnt_clr;
    logic [31:0] in_data, out_data;
    logic [6:0]  in_chk;
    logic [15:0] sec_cnt, ded_cnt;

    typedef struct {
        logic [31:0] d;
        logic        sec;
        logic        ded;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  m_key;
    logic [15:0] m_sec, m_ded;
    logic        stall_prev;
    logic [31:0] hold_d;
    logic [1:0]  hold_f;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [31:0] DB = 32'hDEADBEEF;

    keyed_secded_pipe dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_bit(key_bit), .key_armed(key_armed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sec(out_sec), .out_ded(out_ded), .cnt_clr(cnt_clr),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check bits: low bits are the XOR of the positions of all set data bits
    function automatic logic [6:0] enc(input logic [31:0] d);
        int s;
        int dp;
        logic [6:0] r;
        s  = 0;
        dp = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[dp]) s = s ^ p;
                dp++;
            end
        end
        r[5:0] = 6'(s);
        r[6]   = (^d) ^ (^r[5:0]);
        return r;
    endfunction

    // Decode model: syndrome = XOR of positions of all set codeword bits
    function automatic exp_t model(input logic [31:0] d, input logic [6:0] c, input logic [3:0] key);
        exp_t       r;
        logic [31:0] kd;
        logic [3:0] delta;
        int         s;
        int         dp;
        int         pos_of[32];
        logic       p;
        logic       b;
        kd    = d;
        delta = key ^ 4'b1010;
        for (int j = 0; j < 4; j++) kd[j*8] = kd[j*8] ^ delta[j];
        s  = 0;
        dp = 0;
        p  = c[6];
        for (int x = 1; x <= 38; x++) begin
            b = 1'b0;
            if ((x & (x - 1)) == 0) begin
                for (int k = 0; k < 6; k++) if (x == (1 << k)) b = c[k];
            end else begin
                b = kd[dp];
                pos_of[dp] = x;
                dp++;
            end
            if (b) s = s ^ x;
            p = p ^ b;
        end
        r.d   = kd;
        r.sec = 1'b0;
        r.ded = 1'b0;
        if (p) begin
            if (s > 38) r.ded = 1'b1;
            else begin
                r.sec = 1'b1;
                for (int i = 0; i < 32; i++) if (pos_of[i] == s) r.d[i] = ~kd[i];
            end
        end else if (s != 0) begin
            r.ded = 1'b1;
        end
        return r;
    endfunction

    // One clock cycle, entered and left at a falling edge
    task automatic cyc(input logic v, input logic [31:0] d, input logic [6:0] c, input logic rdy,
                       output logic acc);
        exp_t e;
        in_valid  = v;
        in_data   = d;
        in_chk    = c;
        out_ready = rdy;
        #1;
        chk("sec_cnt", 32'(sec_cnt), 32'(m_sec));
        chk("ded_cnt", 32'(ded_cnt), 32'(m_ded));
        if (stall_prev) begin
            chk("hold_valid", 32'(out_valid), 32'(1'b1));
            chk("hold_data", out_data, hold_d);
            chk("hold_flags", 32'({out_sec, out_ded}), 32'(hold_f));
        end
        if (out_valid && rdy) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'(1'b0));
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_sec", 32'(out_sec), 32'(e.sec));
                chk("out_ded", 32'(out_ded), 32'(e.ded));
                if (e.sec && m_sec != 16'hFFFF) m_sec = m_sec + 16'd1;
                if (e.ded && m_ded != 16'hFFFF) m_ded = m_ded + 16'd1;
            end
        end
        if (cnt_clr) begin
            m_sec = '0;
            m_ded = '0;
        end
        acc = v && in_ready;
        if (acc) q.push_back(model(d, c, m_key));
        stall_prev = out_valid && !rdy;
        hold_d     = out_data;
        hold_f     = {out_sec, out_ded};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 7'd0, 1'b1, a);
    endtask

    task automatic send(input logic [31:0] d, input logic [6:0] c);
        logic a;
        a = 1'b0;
        for (int g = 0; g < 20 && !a; g++) cyc(1'b1, d, c, 1'b1, a);
        chk("send_accepted", 32'(a), 32'(1'b1));
    endtask

    task automatic drain();
        for (int g = 0; g < 20 && q.size() > 0; g++) idle(1);
        chk("drain_empty", 32'(q.size()), 32'd0);
        idle(1);
    endtask

    task automatic load_key(input logic [3:0] k);
        key_load = 1'b1;
        idle(1);
        key_load = 1'b0;
        for (int b = 3; b >= 0; b--) begin
            chk("in_ready_shift", 32'(in_ready), 32'(1'b0));
            key_bit = k[b];
            idle(1);
        end
        m_key = k;
        chk("key_armed", 32'(key_armed), 32'(1'b1));
    endtask

    task automatic clear_model();
        q.delete();
        m_key      = 4'd0;
        m_sec      = '0;
        m_ded      = '0;
        stall_prev = 1'b0;
    endtask

    function automatic logic [31:0] inject(input logic [31:0] d, input int kind);
        logic [31:0] r;
        int a;
        int b;
        r = d;
        a = int'($urandom_range(0, 31));
        b = (a + 1 + int'($urandom_range(0, 30))) % 32;
        if (kind == 1) r[a] = ~r[a];
        if (kind == 2) begin
            r[a] = ~r[a];
            r[b] = ~r[b];
        end
        return r;
    endfunction

    initial begin
        logic        a;
        logic [31:0] w[8];
        logic [6:0]  wc[8];
        logic [6:0]  c;
        int          idx;
        int          kind;
        logic        rpat[4];

        rst_n = 1'b1; key_load = 1'b0; key_bit = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; in_chk = '0; out_ready = 1'b0;
        clear_model();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_key_armed", 32'(key_armed), 32'(1'b0));
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_flags", 32'({out_sec, out_ded}), 32'd0);
        chk("rst_counters", {sec_cnt, ded_cnt}, 32'd0);
        rst_n = 1'b1;

        // Unlocked: key_reg=0 must not decode DEADBEEF cleanly
        c = enc(DB);
        send(DB, c);
        idle(1);
        chk("nokey_corrupt", 32'((out_data !== DB) || out_sec || out_ded), 32'(1'b1));
        drain();

        load_key(4'b1010);

        // Clean word and two-cycle latency
        cyc(1'b1, DB, c, 1'b1, a);
        chk("lat_cycle1", 32'(out_valid), 32'(1'b0));
        idle(1);
        chk("lat_cycle2", 32'(out_valid), 32'(1'b1));
        chk("clean_data", out_data, DB);
        chk("clean_flags", 32'({out_sec, out_ded}), 32'd0);
        drain();

        send(DB ^ 32'h20, c);
        drain();
        chk("sec_cnt_one", 32'(sec_cnt), 32'(m_sec));
        send(DB, c ^ 7'h40);
        send(DB, c ^ 7'h04);
        send(DB ^ 32'h3, c);
        drain();

        // Back-to-back with out_ready pattern 1,0,0,1
        rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            w[i]  = $urandom;
            wc[i] = enc(w[i]);
            w[i]  = inject(w[i], int'($urandom_range(0, 2)));
        end
        idx = 0;
        for (int g = 0; g < 100 && idx < 8; g++) begin
            cyc(1'b1, w[idx], wc[idx], rpat[g % 4], a);
            if (a) idx++;
        end
        chk("b2b_all_sent", 32'(idx), 32'd8);
        drain();

        // Random traffic with random backpressure and error kinds
        idx = 0;
        for (int g = 0; g < 2000 && idx < 200; g++) begin
            if (idx < 200) begin
                if (!stall_prev || g == 0) begin
                    w[0]  = $urandom;
                    wc[0] = enc(w[0]);
                    kind  = int'($urandom_range(0, 3));
                    w[0]  = inject(w[0], kind);
                    if (kind == 3) wc[0][$urandom_range(0, 6)] ^= 1'b1;
                end
            end
            cyc(1'b1, w[0], wc[0], ($urandom_range(0, 9) < 7), a);
            if (a) begin
                idx++;
                w[0]  = $urandom;
                wc[0] = enc(w[0]);
                kind  = int'($urandom_range(0, 3));
                w[0]  = inject(w[0], kind);
                if (kind == 3) wc[0][$urandom_range(0, 6)] ^= 1'b1;
            end
        end
        chk("rand_all_sent", 32'(idx), 32'd200);
        drain();

        // Saturation and clear priority
        force dut.r_sec_cnt = 16'hFFFF;
        #1 release dut.r_sec_cnt;
        m_sec = 16'hFFFF;
        send(DB ^ 32'h100, c);
        drain();
        chk("sec_saturated", 32'(sec_cnt), 32'h0000FFFF);
        cnt_clr = 1'b1;
        send(DB ^ 32'h1, c);
        send(DB ^ 32'h6, c);
        drain();
        cnt_clr = 1'b0;
        idle(1);
        chk("clr_wins", {sec_cnt, ded_cnt}, 32'd0);

        // Reset in the middle of a key load with a word in flight
        send(DB, c);
        key_load = 1'b1;
        idle(1);
        key_load = 1'b0;
        key_bit  = 1'b1;
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_key_armed", 32'(key_armed), 32'(1'b0));
        chk("midrst_out_valid", 32'(out_valid), 32'(1'b0));
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        send(DB, c);
        drain();
        load_key(4'b1010);
        send(DB, c);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
